// File: rtl/sc_statemachine_lane_if.sv
// Button/crash inputs and display-control outputs of the lane state machine.
// master drives the buttons and watches the outputs; slave is the state machine.
interface sc_statemachine_lane_if #(
  parameter int WIDTH = 8
);
  localparam int PW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

  logic             SC_STATEMACHINE_LANE_startButton_InLow;
  logic             SC_STATEMACHINE_LANE_leftButton_InLow;
  logic             SC_STATEMACHINE_LANE_rightButton_InLow;
  logic             SC_STATEMACHINE_LANE_crash_InHigh;
  logic [PW-1:0]    SC_STATEMACHINE_LANE_position_Out;
  logic [WIDTH-1:0] SC_STATEMACHINE_LANE_lane_Out;
  logic             SC_STATEMACHINE_LANE_clear_OutLow;
  logic             SC_STATEMACHINE_LANE_load_OutLow;
  logic [1:0]       SC_STATEMACHINE_LANE_shiftselection_Out;
  logic             SC_STATEMACHINE_LANE_crashed_Out;

  modport master (
    output SC_STATEMACHINE_LANE_startButton_InLow, SC_STATEMACHINE_LANE_leftButton_InLow,
           SC_STATEMACHINE_LANE_rightButton_InLow, SC_STATEMACHINE_LANE_crash_InHigh,
    input  SC_STATEMACHINE_LANE_position_Out, SC_STATEMACHINE_LANE_lane_Out,
           SC_STATEMACHINE_LANE_clear_OutLow, SC_STATEMACHINE_LANE_load_OutLow,
           SC_STATEMACHINE_LANE_shiftselection_Out, SC_STATEMACHINE_LANE_crashed_Out
  );

  modport slave (
    input  SC_STATEMACHINE_LANE_startButton_InLow, SC_STATEMACHINE_LANE_leftButton_InLow,
           SC_STATEMACHINE_LANE_rightButton_InLow, SC_STATEMACHINE_LANE_crash_InHigh,
    output SC_STATEMACHINE_LANE_position_Out, SC_STATEMACHINE_LANE_lane_Out,
           SC_STATEMACHINE_LANE_clear_OutLow, SC_STATEMACHINE_LANE_load_OutLow,
           SC_STATEMACHINE_LANE_shiftselection_Out, SC_STATEMACHINE_LANE_crashed_Out
  );
endinterface

// File: rtl/sc_statemachine_lane.sv
// Player lane controller: moves a one-hot marker left/right with button auto-repeat,
// freezes for a fixed time after a collision, then respawns at INIT_POS.
module sc_statemachine_lane #(
  parameter int WIDTH         = 8,
  parameter int INIT_POS      = 4,
  parameter int REPEAT_CYCLES = 12_500_000,
  parameter int CRASH_CYCLES  = 25_000_000
) (
  input  logic                  SC_STATEMACHINE_LANE_CLOCK_50,
  input  logic                  SC_STATEMACHINE_LANE_RESET_InLow,
  sc_statemachine_lane_if.slave bus
);
  localparam int PW   = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam int MAXC = (REPEAT_CYCLES > CRASH_CYCLES) ? REPEAT_CYCLES : CRASH_CYCLES;
  localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  localparam logic [PW-1:0] POS_MAX  = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_INIT = PW'(INIT_POS);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CR_LAST  = CW'(CRASH_CYCLES - 1);

  typedef enum logic [3:0] {
    RESET, WAIT_START, INIT_0, INIT_1, CHECK, LEFT, RIGHT, HOLD, CRASH
  } state_t;

  state_t        state, stateNext;
  logic [PW-1:0] position, positionNext;
  logic [CW-1:0] repeatCnt, repeatCntNext;
  logic [CW-1:0] crashCnt, crashCntNext;
  logic          clearLow, loadLow, crashed;
  logic [1:0]    shiftSel;

  logic startN, leftN, rightN, crash;
  assign startN = bus.SC_STATEMACHINE_LANE_startButton_InLow;
  assign leftN  = bus.SC_STATEMACHINE_LANE_leftButton_InLow;
  assign rightN = bus.SC_STATEMACHINE_LANE_rightButton_InLow;
  assign crash  = bus.SC_STATEMACHINE_LANE_crash_InHigh;

  always_ff @(posedge SC_STATEMACHINE_LANE_CLOCK_50) begin
    if (!SC_STATEMACHINE_LANE_RESET_InLow) begin
      state     <= RESET;
      position  <= POS_INIT;
      repeatCnt <= '0;
      crashCnt  <= '0;
    end else begin
      state     <= stateNext;
      position  <= positionNext;
      repeatCnt <= repeatCntNext;
      crashCnt  <= crashCntNext;
    end
  end

  // Counters self-clear in every state that does not advance them.
  always_comb begin
    stateNext     = state;
    positionNext  = position;
    repeatCntNext = '0;
    crashCntNext  = '0;
    clearLow      = 1'b1;
    loadLow       = 1'b1;
    shiftSel      = 2'b11;
    crashed       = 1'b0;
    case (state)
      RESET:      stateNext = WAIT_START;
      WAIT_START: if (!startN) stateNext = INIT_0;
      INIT_0: begin
        clearLow     = 1'b0;
        positionNext = '0;
        stateNext    = INIT_1;
      end
      INIT_1: begin
        loadLow      = 1'b0;
        positionNext = POS_INIT;
        stateNext    = HOLD;
      end
      CHECK: begin
        if (crash)                                 stateNext = CRASH;
        else if (!startN)                          stateNext = INIT_0;
        else if (!leftN && !rightN)                stateNext = CHECK;
        else if (!leftN && position != '0)         stateNext = LEFT;
        else if (!rightN && position != POS_MAX)   stateNext = RIGHT;
        else if (!leftN || !rightN)                stateNext = HOLD;
      end
      LEFT: begin
        shiftSel = 2'b01;
        if (position != '0) positionNext = position - 1'b1;
        stateNext = crash ? CRASH : HOLD;
      end
      RIGHT: begin
        shiftSel = 2'b10;
        if (position != POS_MAX) positionNext = position + 1'b1;
        stateNext = crash ? CRASH : HOLD;
      end
      HOLD: begin
        if (crash)                          stateNext = CRASH;
        else if (startN && leftN && rightN) stateNext = CHECK;
        else if (repeatCnt == REP_LAST)     stateNext = CHECK;
        else                                repeatCntNext = repeatCnt + 1'b1;
      end
      CRASH: begin
        crashed = 1'b1;
        if (crashCnt == CR_LAST) stateNext = INIT_1;
        else                     crashCntNext = crashCnt + 1'b1;
      end
      default: stateNext = CHECK;
    endcase
  end

  assign bus.SC_STATEMACHINE_LANE_position_Out       = position;
  assign bus.SC_STATEMACHINE_LANE_lane_Out           = {{(WIDTH-1){1'b0}}, 1'b1} << position;
  assign bus.SC_STATEMACHINE_LANE_clear_OutLow       = clearLow;
  assign bus.SC_STATEMACHINE_LANE_load_OutLow        = loadLow;
  assign bus.SC_STATEMACHINE_LANE_shiftselection_Out = shiftSel;
  assign bus.SC_STATEMACHINE_LANE_crashed_Out        = crashed;
endmodule

// File: tb/tb_sc_statemachine_lane.sv
// Directed bench: one table of per-cycle vectors plus hand sequences for
// right-edge walking, start re-init, and reset during HOLD/CRASH.
module tb_sc_statemachine_lane;
  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sc_statemachine_lane_if #(.WIDTH(8)) bus ();

  sc_statemachine_lane #(
    .WIDTH(8), .INIT_POS(4), .REPEAT_CYCLES(4), .CRASH_CYCLES(6)
  ) dut (
    .SC_STATEMACHINE_LANE_CLOCK_50  (clk),
    .SC_STATEMACHINE_LANE_RESET_InLow(rstN),
    .bus                            (bus)
  );

  typedef struct {
    logic       s, l, r, c;
    int         pos;
    logic       clr, ld;
    logic [1:0] sh;
    logic       cr;
  } vec_t;
  vec_t vq[$];

  task automatic addv(input logic s, l, r, c, input int pos,
                      input logic clr, ld, input logic [1:0] sh, input logic cr);
    vec_t v;
    v.s = s; v.l = l; v.r = r; v.c = c; v.pos = pos;
    v.clr = clr; v.ld = ld; v.sh = sh; v.cr = cr;
    vq.push_back(v);
  endtask

  task automatic step(input logic s, l, r, c);
    bus.SC_STATEMACHINE_LANE_startButton_InLow = s;
    bus.SC_STATEMACHINE_LANE_leftButton_InLow  = l;
    bus.SC_STATEMACHINE_LANE_rightButton_InLow = r;
    bus.SC_STATEMACHINE_LANE_crash_InHigh      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int ep, input logic eclr, eld,
                     input logic [1:0] esh, input logic ecr);
    logic [7:0] el;
    el = 8'd1 << ep;
    checks++;
    if (bus.SC_STATEMACHINE_LANE_position_Out !== 3'(ep) ||
        bus.SC_STATEMACHINE_LANE_lane_Out !== el ||
        bus.SC_STATEMACHINE_LANE_clear_OutLow !== eclr ||
        bus.SC_STATEMACHINE_LANE_load_OutLow !== eld ||
        bus.SC_STATEMACHINE_LANE_shiftselection_Out !== esh ||
        bus.SC_STATEMACHINE_LANE_crashed_Out !== ecr) begin
      errors++;
      $display("FAIL %s: got pos=%0d lane=%b clr=%b ld=%b sh=%b crashed=%b, expected pos=%0d lane=%b clr=%b ld=%b sh=%b crashed=%b",
               nm, bus.SC_STATEMACHINE_LANE_position_Out, bus.SC_STATEMACHINE_LANE_lane_Out,
               bus.SC_STATEMACHINE_LANE_clear_OutLow, bus.SC_STATEMACHINE_LANE_load_OutLow,
               bus.SC_STATEMACHINE_LANE_shiftselection_Out, bus.SC_STATEMACHINE_LANE_crashed_Out,
               ep, el, eclr, eld, esh, ecr);
    end
  endtask

  task automatic chkInt(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    int pulses;
    int bad;

    // s l r c | pos clr ld sh cr   (buttons active-low, sampled after the edge)
    addv(1,1,1,0, 4,1,1,2'b11,0);  // RESET -> WAIT_START
    addv(1,1,1,0, 4,1,1,2'b11,0);
    addv(1,0,1,1, 4,1,1,2'b11,0);  // left/crash ignored while waiting
    addv(0,1,1,0, 4,0,1,2'b11,0);  // INIT_0 clear pulse
    addv(1,1,1,0, 0,1,0,2'b11,0);  // INIT_1 load pulse, position 0
    addv(1,1,1,0, 4,1,1,2'b11,0);  // HOLD at INIT_POS
    addv(1,1,1,0, 4,1,1,2'b11,0);  // CHECK
    addv(1,1,1,0, 4,1,1,2'b11,0);
    addv(1,0,1,0, 4,1,1,2'b01,0);  // LEFT 4->3
    for (int i = 0; i < 5; i++) addv(1,0,1,0, 3,1,1,2'b11,0);  // HOLD x4, CHECK
    addv(1,0,1,0, 3,1,1,2'b01,0);  // auto-repeat LEFT 3->2
    for (int i = 0; i < 5; i++) addv(1,0,1,0, 2,1,1,2'b11,0);
    addv(1,0,1,0, 2,1,1,2'b01,0);  // LEFT 2->1
    addv(1,0,1,0, 1,1,1,2'b11,0);  // HOLD
    addv(1,1,1,0, 1,1,1,2'b11,0);  // release -> CHECK
    addv(1,1,1,0, 1,1,1,2'b11,0);
    addv(1,0,1,0, 1,1,1,2'b01,0);  // LEFT 1->0
    for (int i = 0; i < 5; i++) addv(1,0,1,0, 0,1,1,2'b11,0);
    addv(1,0,1,0, 0,1,1,2'b11,0);  // left at 0: HOLD, no move
    addv(1,0,1,0, 0,1,1,2'b11,0);
    addv(1,1,1,0, 0,1,1,2'b11,0);  // CHECK
    addv(1,0,0,0, 0,1,1,2'b11,0);  // both low: no move
    addv(1,0,0,0, 0,1,1,2'b11,0);
    addv(1,1,1,0, 0,1,1,2'b11,0);
    addv(1,1,0,0, 0,1,1,2'b10,0);  // RIGHT 0->1
    addv(1,1,0,0, 1,1,1,2'b11,0);  // HOLD
    addv(1,1,0,1, 1,1,1,2'b11,1);  // crash -> CRASH
    for (int i = 0; i < 5; i++) addv(0,0,1,1, 1,1,1,2'b11,1);  // frozen, inputs ignored
    addv(0,0,1,1, 1,1,0,2'b11,0);  // INIT_1 respawn load
    addv(1,1,1,0, 4,1,1,2'b11,0);  // HOLD at 4
    addv(1,1,1,0, 4,1,1,2'b11,0);  // CHECK

    rstN = 1'b0;
    step(1,1,1,0); chk("reset0", 4,1,1,2'b11,0);
    step(0,0,0,1); chk("reset1", 4,1,1,2'b11,0);
    rstN = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].s, vq[i].l, vq[i].r, vq[i].c);
      chk($sformatf("vec%0d", i), vq[i].pos, vq[i].clr, vq[i].ld, vq[i].sh, vq[i].cr);
    end

    // Walk right from 4 and hold at the right edge: exactly three moves.
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(1,1,0,0);
      if (bus.SC_STATEMACHINE_LANE_shiftselection_Out == 2'b10) pulses++;
    end
    chkInt("right_pulses", pulses, 3);
    chkInt("right_edge_pos", int'(bus.SC_STATEMACHINE_LANE_position_Out), 7);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(1,0,0,0);
      if (bus.SC_STATEMACHINE_LANE_shiftselection_Out != 2'b11 ||
          bus.SC_STATEMACHINE_LANE_position_Out != 3'd7) bad++;
    end
    chkInt("both_low_no_move", bad, 0);
    step(1,1,1,0); step(1,1,1,0); chk("settle7", 7,1,1,2'b11,0);
    step(1,0,1,0); chk("left7", 7,1,1,2'b01,0);
    step(1,0,1,0); chk("at6", 6,1,1,2'b11,0);
    step(1,1,1,0); chk("check6", 6,1,1,2'b11,0);
    step(0,1,1,0); chk("restart_clr", 6,0,1,2'b11,0);
    step(1,1,1,0); chk("restart_ld", 0,1,0,2'b11,0);
    step(1,1,1,0); chk("restart_pos", 4,1,1,2'b11,0);

    // Reset while in HOLD at position 3.
    step(1,1,1,0); chk("hold_check", 4,1,1,2'b11,0);
    step(1,0,1,0); chk("hold_left", 4,1,1,2'b01,0);
    step(1,0,1,0); chk("hold_at3", 3,1,1,2'b11,0);
    step(1,0,1,0); chk("hold_at3b", 3,1,1,2'b11,0);
    rstN = 1'b0;
    step(1,0,1,0); chk("rst_in_hold", 4,1,1,2'b11,0);
    rstN = 1'b1;
    step(0,1,1,0); chk("rst_to_wait", 4,1,1,2'b11,0);
    step(0,1,1,0); chk("wait_start", 4,0,1,2'b11,0);
    step(1,1,1,0); chk("init1_again", 0,1,0,2'b11,0);
    step(1,1,1,0); chk("hold_again", 4,1,1,2'b11,0);
    step(1,1,1,0); chk("check_again", 4,1,1,2'b11,0);

    // Reset while frozen in CRASH.
    step(1,1,1,1); chk("crash_from_check", 4,1,1,2'b11,1);
    step(1,1,1,0); chk("crash_mid", 4,1,1,2'b11,1);
    rstN = 1'b0;
    step(1,1,1,1); chk("rst_in_crash", 4,1,1,2'b11,0);
    rstN = 1'b1;
    step(1,1,1,1); chk("after_rst_crash", 4,1,1,2'b11,0);
    step(1,1,1,1); chk("wait_ignores_crash", 4,1,1,2'b11,0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
